// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush sequencing, data-memory wait
// stalls with a sticky timeout flag, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_is_load,
  input  logic [4:0]           mem1_rd,
  input  logic                 mem1_is_load,
  input  logic                 br_taken,
  input  logic                 dmem_busy,
  input  logic                 clr_stats,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [3:0]           FL_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0]          WAIT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           fl_cnt_q, fl_cnt_d;
  logic [15:0]          wait_cnt_q, wait_cnt_d;
  logic [15:0]          wait_inc;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_hit, mem1_hit, luh;
  logic st_if, st_id, st_ex, st_mem, fl_id, fl_ex, flush_evt;

  // A load targeting x0 never produces a value anyone waits for.
  always_comb begin
    ex_hit   = ex_is_load && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    mem1_hit = mem1_is_load && (mem1_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == mem1_rd)) || (id_rs2_used && (id_rs2 == mem1_rd)));
    luh      = ex_hit || mem1_hit;
  end

  assign wait_inc = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    fl_cnt_d   = fl_cnt_q;
    wait_cnt_d = '0;
    st_if      = 1'b0;
    st_id      = 1'b0;
    st_ex      = 1'b0;
    st_mem     = 1'b0;
    fl_id      = 1'b0;
    fl_ex      = 1'b0;
    flush_evt  = 1'b0;

    case (state_q)
      FLUSH: begin
        if (dmem_busy) begin
          // Memory wait freezes the flush sequence but still counts toward timeout.
          {st_if, st_id, st_ex, st_mem} = 4'b1111;
          wait_cnt_d = wait_inc;
        end else begin
          fl_id = 1'b1;
          fl_ex = 1'b1;
          if (fl_cnt_q <= 4'd1) begin
            fl_cnt_d = '0;
            state_d  = RUN;
          end else begin
            fl_cnt_d = fl_cnt_q - 4'd1;
          end
        end
      end

      // RUN, MEM_WAIT and the unused encoding share the run-time priority decode.
      default: begin
        if (dmem_busy) begin
          {st_if, st_id, st_ex, st_mem} = 4'b1111;
          wait_cnt_d = (state_q == MEM_WAIT) ? wait_inc : 16'd1;
          state_d    = MEM_WAIT;
        end else if (br_taken) begin
          fl_id     = 1'b1;
          fl_ex     = 1'b1;
          flush_evt = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = FLUSH;
            fl_cnt_d = FL_RELOAD;
          end else begin
            state_d  = RUN;
            fl_cnt_d = '0;
          end
        end else if (luh) begin
          // Bubble: hold IF/ID, clear EX so the consumer waits one slot per cycle.
          st_if   = 1'b1;
          st_id   = 1'b1;
          fl_ex   = 1'b1;
          state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q || (32'(wait_cnt_d) >= TIMEOUT);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (st_if && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush_evt && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      fl_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      fl_cnt_q      <= fl_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // The combinational controls must drop the moment reset asserts, not at the next edge.
  assign stall_if     = reset & st_if;
  assign stall_id     = reset & st_id;
  assign stall_ex     = reset & st_ex;
  assign stall_mem    = reset & st_mem;
  assign flush_id     = reset & fl_id;
  assign flush_ex     = reset & fl_ex;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model predicts each cycle's
// controls and counters; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned TIMEOUT      = 4;
  localparam int unsigned CNT_WIDTH    = 6;
  localparam int          CNT_MAX      = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem1_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, mem1_is_load, br_taken, dmem_busy, clr_stats;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_timeout;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_events;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .TIMEOUT     (TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .mem1_rd     (mem1_rd),
    .mem1_is_load(mem1_is_load),
    .br_taken    (br_taken),
    .dmem_busy   (dmem_busy),
    .clr_stats   (clr_stats),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .stall_mem   (stall_mem),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs1, rs2, exrd, m1rd;
    bit u1, u2, exld, m1ld, br, busy, clr;
  } stim_t;

  typedef struct {
    logic [3:0] stalls;   // {if, id, ex, mem}
    logic [1:0] flushes;  // {id, ex}
    logic       to;
    int         sc;
    int         fe;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: remaining forced flush cycles, busy streak, sticky flag, counters.
  int m_flush_left, m_streak, m_sc, m_fe;
  bit m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("stalls", {28'd0, stall_if, stall_id, stall_ex, stall_mem}, {28'd0, e.stalls});
      check("flushes", {30'd0, flush_id, flush_ex}, {30'd0, e.flushes});
      check("mem_timeout", {31'd0, mem_timeout}, {31'd0, e.to});
      check("stall_cycles", 32'(stall_cycles), e.sc);
      check("flush_events", 32'(flush_events), e.fe);
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s.rs1 = 0; s.rs2 = 0; s.exrd = 0; s.m1rd = 0;
    s.u1 = 0; s.u2 = 0; s.exld = 0; s.m1ld = 0; s.br = 0; s.busy = 0; s.clr = 0;
    return s;
  endfunction

  function automatic bit reads(input stim_t s, input int r);
    return (r != 0) && ((s.u1 && s.rs1 == r) || (s.u2 && s.rs2 == r));
  endfunction

  function automatic bit hazard(input stim_t s);
    return (s.exld && reads(s, s.exrd)) || (s.m1ld && reads(s, s.m1rd));
  endfunction

  task automatic apply(input stim_t s);
    id_rs1 = 5'(s.rs1); id_rs2 = 5'(s.rs2); ex_rd = 5'(s.exrd); mem1_rd = 5'(s.m1rd);
    id_rs1_used = s.u1; id_rs2_used = s.u2; ex_is_load = s.exld; mem1_is_load = s.m1ld;
    br_taken = s.br; dmem_busy = s.busy; clr_stats = s.clr;
  endtask

  task automatic model_reset();
    m_flush_left = 0; m_streak = 0; m_sc = 0; m_fe = 0; m_to = 0;
  endtask

  // Drive one cycle at posedge+1, predict it, advance the model across the coming edge.
  task automatic step(input stim_t s);
    exp_t e;
    bit flush_evt;
    apply(s);
    e.stalls = 4'b0000;
    e.flushes = 2'b00;
    flush_evt = 0;
    if (s.busy) e.stalls = 4'b1111;
    else if (m_flush_left > 0) e.flushes = 2'b11;
    else if (s.br) begin
      e.flushes = 2'b11;
      flush_evt = 1;
    end else if (hazard(s)) begin
      e.stalls = 4'b1100;
      e.flushes = 2'b01;
    end
    e.to = m_to; e.sc = m_sc; e.fe = m_fe;
    sb.push_back(e);
    if (s.busy) begin
      m_streak++;
      if (m_streak >= int'(TIMEOUT)) m_to = 1;
    end else begin
      m_streak = 0;
      if (m_flush_left > 0) m_flush_left--;
      else if (flush_evt) m_flush_left = int'(FLUSH_CYCLES) - 1;
    end
    if (s.clr) begin
      m_sc = 0;
      m_fe = 0;
    end else begin
      if (e.stalls[3] && m_sc < CNT_MAX) m_sc++;
      if (flush_evt && m_fe < CNT_MAX) m_fe++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex},
          32'd0);
    check({tag, "_cnt"}, {19'd0, mem_timeout, stall_cycles, flush_events}, 32'd0);
  endtask

  task automatic do_reset();
    apply(idle());
    reset = 1'b0;
    #3;
    check_outputs_zero("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  function automatic int pick_reg();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 1;
      2: return 2;
      default: return 5;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int burst;
    apply(idle());
    model_reset();
    do_reset();

    // x0 load destination never stalls.
    s = idle(); s.exld = 1; s.exrd = 0; s.rs2 = 0; s.u2 = 1;
    step(s);
    step(idle());
    check("zero_reg_stall_cycles", 32'(stall_cycles), 32'd0);

    // EX load then same load in MEM1: two bubble cycles.
    s = idle(); s.exld = 1; s.exrd = 5; s.rs1 = 5; s.u1 = 1;
    step(s);
    s.exld = 0; s.exrd = 0; s.m1ld = 1; s.m1rd = 5;
    step(s);
    s = idle(); s.rs1 = 5; s.u1 = 1;
    step(s);
    check("load_use_stall_cycles", 32'(stall_cycles), 32'd2);

    // Branch held for two cycles: one event, two flush cycles.
    s = idle(); s.br = 1;
    step(s);
    step(s);
    step(idle());
    check("branch_flush_events", 32'(flush_events), 32'd1);

    // Busy during the second flush cycle freezes the flush.
    s = idle(); s.br = 1;
    step(s);
    s = idle(); s.busy = 1;
    step(s); step(s); step(s);
    step(idle());
    step(idle());
    check("busy_in_flush_events", 32'(flush_events), 32'd2);

    // Timeout after the fourth consecutive busy edge, sticky afterwards.
    do_reset();
    s = idle(); s.busy = 1;
    for (int i = 0; i < 3; i++) step(s);
    check("timeout_before", {31'd0, mem_timeout}, 32'd0);
    step(s);
    check("timeout_after_4", {31'd0, mem_timeout}, 32'd1);
    step(s); step(s);
    for (int i = 0; i < 3; i++) step(idle());
    check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

    // Reset in the middle of a flush with three flush events recorded.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      s = idle(); s.br = 1;
      step(s);
      step(idle());
      step(idle());
    end
    s = idle(); s.br = 1;
    step(s);
    check("pre_reset_flush_events", 32'(flush_events), 32'd3);
    apply(s);
    #2;
    check("mid_flush_flush_id", {31'd0, flush_id}, 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    do_reset();

    // Randomised phases, with a reset between each to re-arm the sticky timeout.
    for (int ph = 0; ph < 4; ph++) begin
      burst = 0;
      for (int c = 0; c < 250; c++) begin
        s = idle();
        s.rs1 = pick_reg(); s.rs2 = pick_reg(); s.exrd = pick_reg(); s.m1rd = pick_reg();
        s.u1 = ($urandom_range(0, 3) != 0); s.u2 = ($urandom_range(0, 1) != 0);
        s.exld = ($urandom_range(0, 2) == 0); s.m1ld = ($urandom_range(0, 2) == 0);
        s.br = ($urandom_range(0, 9) == 0);
        s.clr = ($urandom_range(0, 49) == 0);
        if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(2, 6);
        if (burst > 0) begin
          s.busy = 1;
          burst--;
        end else begin
          s.busy = ($urandom_range(0, 9) == 0);
        end
        step(s);
      end
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter FLUSH_CYCLES, default 2, giving the flush pulse length in cycles, legal range 1..15.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, giving the consecutive dmem_busy cycles before error, legal range 1..65535.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, giving the statistics counter width.
REQ-004 Port clk  input  1  is the single clock; every flop SHALL be rising-edge.
REQ-005 Port reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Ports id_rs1, id_rs2  input  5 each  SHALL carry the ID-stage source register indices.
REQ-007 Ports id_rs1_used, id_rs2_used  input  1 each  SHALL qualify the matching source index.
REQ-008 Ports ex_rd  input  5  and ex_is_load  input  1  SHALL describe the instruction in EX.
REQ-009 Ports mem1_rd  input  5  and mem1_is_load  input  1  SHALL describe the instruction in MEM1.
REQ-010 Port br_taken  input  1  SHALL mean a branch or jump resolved taken in EX.
REQ-011 Port dmem_busy  input  1  SHALL mean data memory is not ready this cycle.
REQ-012 Port clr_stats  input  1  SHALL be a synchronous clear for the statistics counters.
REQ-013 Ports stall_if, stall_id, stall_ex, stall_mem  output  1 each  SHALL be hold enables for the pipeline registers (stall_mem covers MEM1 and MEM2).
REQ-014 Ports flush_id, flush_ex  output  1 each  SHALL drive the clr inputs of the ID and EX pipeline registers.
REQ-015 Port mem_timeout  output  1  SHALL be a sticky memory-timeout error flag.
REQ-016 Ports stall_cycles, flush_events  output  CNT_WIDTH each  SHALL be statistics counters.

Function
REQ-017 The module SHALL implement states RUN, FLUSH and MEM_WAIT; state, counters and mem_timeout SHALL be registered, while stall and flush outputs SHALL be combinational from the current state and inputs.
REQ-018 The load-use hazard luh SHALL be 1 when either of these holds, with rd==0 never a hazard:
- (ex_is_load and ex_rd != 0) and ex_rd matches a used ID source;
- (mem1_is_load and mem1_rd != 0) and mem1_rd matches a used ID source.
REQ-019 In RUN, priority SHALL be dmem_busy > br_taken > luh.
REQ-020 RUN with dmem_busy=1 SHALL assert all four stalls this cycle, drive flushes 0 and go to MEM_WAIT with wait_cnt=1.
REQ-021 RUN with br_taken=1 and dmem_busy=0 SHALL assert flush_id=flush_ex=1 this cycle; if FLUSH_CYCLES>1 it SHALL go to FLUSH with fl_cnt=FLUSH_CYCLES-1, else it SHALL stay in RUN; flush_events SHALL increment.
REQ-022 RUN with luh=1 and no higher-priority event SHALL assert stall_if=stall_id=flush_ex=1, hold stall_ex=stall_mem=0 (bubble insertion) and stay in RUN, giving 2 stall cycles for an EX load and 1 for a MEM1 load.
REQ-023 FLUSH with dmem_busy=0 SHALL assert flush_id=flush_ex=1 and decrement fl_cnt, going to RUN when fl_cnt reaches 0; br_taken and luh SHALL be ignored.
REQ-024 FLUSH with dmem_busy=1 SHALL assert all stalls, drive flushes 0, freeze fl_cnt and stay in FLUSH; the wait SHALL count toward timeout.
REQ-025 MEM_WAIT with dmem_busy=1 SHALL assert all stalls and increment wait_cnt, saturating.
REQ-026 MEM_WAIT with dmem_busy=0 SHALL behave as RUN for that cycle (REQ-019..022) and clear wait_cnt.
REQ-027 mem_timeout SHALL set on the edge ending the TIMEOUT-th consecutive busy cycle and SHALL remain set until reset.
REQ-028 stall_cycles SHALL increment each cycle stall_if=1; both counters SHALL saturate at all-ones, and clr_stats SHALL zero them with clear winning over a same-cycle increment.

Reset
REQ-029 While reset=0, the module SHALL force state RUN, fl_cnt=0, wait_cnt=0, mem_timeout=0, counters=0 and all stall/flush outputs 0 immediately, regardless of clk; in-progress flush or wait SHALL be abandoned.

Verification
REQ-030 Load-use from EX: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1, then the load moves to MEM1 -> stall_if/stall_id/flush_ex=1 for exactly 2 cycles and stall_cycles=2.
REQ-031 Zero register: load with ex_rd=0 and id_rs2=0 used -> no stall or flush and stall_cycles=0.
REQ-032 Branch: br_taken=1 for 2 cycles from RUN -> flush_id/flush_ex=1 for exactly 2 cycles and flush_events=1.
REQ-033 Busy in flush: dmem_busy=1 for 3 cycles starting in the second flush cycle -> stalls=1 and flushes=0 for 3 cycles, then 1 more flush cycle, then RUN.
REQ-034 Timeout: TIMEOUT=4, dmem_busy=1 for 6 cycles -> mem_timeout rises after the 4th busy edge and stays 1 after busy drops until reset=0.
REQ-035 Reset mid-operation: reset=0 mid-FLUSH with flush_events=3 -> outputs 0 without a clock edge and counters 0.
